// File: rtl/hit_input_encoder.sv
// -----------------------------------------------------------------------------
// hit_input_encoder
//
// Front end of the mole match logic. Takes the byte stream from the PS/2
// receiver (scan code set 2) and turns it into:
//   - a one-cycle 3-bit hit code (1..5) for a fresh press of a mole key,
//   - a one-cycle start pulse for a fresh press of the space bar,
//   - a level per mole key showing which keys are currently down.
//
// Make codes are acted on, break codes (F0 prefix) release keys, and extended
// codes (E0 prefix) are swallowed. Typematic repeats are suppressed because a
// make for a key that is already down is ignored. After each emitted hit a
// short cooldown drops further hit makes, so one press scores exactly once.
//
// Parameters:
//   COOLDOWN       cycles after an emitted hit during which hit makes are
//                  dropped (0 disables the cooldown)
//   PREFIX_TIMEOUT idle cycles allowed in a prefix state before the partial
//                  sequence is abandoned (must be >= 1)
//
// Ports:
//   clock        in   1  system clock
//   reset        in   1  asynchronous, active-high
//   scan_code    in   8  received PS/2 byte, valid when scan_valid=1
//   scan_valid   in   1  one-cycle strobe per received byte
//   enable       in   1  game active; gates hit emission only
//   hit_code     out  3  registered; 1..5 for one cycle on an accepted hit
//   start_pulse  out  1  registered; one-cycle pulse on a fresh space make
//   key_held     out  5  bit k set while mole key k+1 is down
// -----------------------------------------------------------------------------
module hit_input_encoder #(
    parameter int COOLDOWN       = 4,
    parameter int PREFIX_TIMEOUT = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       enable,
    output logic [2:0] hit_code,
    output logic       start_pulse,
    output logic [4:0] key_held
);

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // The timeout counter only ever holds 0..PREFIX_TIMEOUT-1; the cycle on
    // which it would reach PREFIX_TIMEOUT is the cycle that leaves the prefix.
    localparam int TMO_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TIMEOUT - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN);

    typedef enum logic [1:0] {
        WAIT_CODE = 2'd0,
        GOT_E0    = 2'd1,
        GOT_F0    = 2'd2,
        GOT_E0F0  = 2'd3
    } state_t;

    // Mole key lookup: returns 1..5 for a mapped key, 0 otherwise.
    function automatic logic [2:0] f_key_index(input logic [7:0] code);
        logic [2:0] idx;
        idx = 3'd0;
        case (code)
            8'h16:   idx = 3'd1;
            8'h1E:   idx = 3'd2;
            8'h26:   idx = 3'd3;
            8'h25:   idx = 3'd4;
            8'h2E:   idx = 3'd5;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

    // One-hot key_held position for a key index (index 0 gives no bit).
    function automatic logic [4:0] f_key_mask(input logic [2:0] idx);
        logic [4:0] mask;
        mask = 5'b00000;
        case (idx)
            3'd1:    mask = 5'b00001;
            3'd2:    mask = 5'b00010;
            3'd3:    mask = 5'b00100;
            3'd4:    mask = 5'b01000;
            3'd5:    mask = 5'b10000;
            default: mask = 5'b00000;
        endcase
        return mask;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_next;
    logic             w_make;
    logic             w_break;

    logic [4:0]       r_key_held;
    logic             r_space_held;
    logic [CD_W-1:0]  r_cooldown;
    logic [2:0]       r_hit_code;
    logic             r_start_pulse;

    logic [2:0]       w_key_idx;
    logic [4:0]       w_key_mask;
    logic             w_fresh_key_make;
    logic             w_emit_hit;
    logic             w_space_make;
    logic             w_space_break;
    logic [4:0]       w_set_mask;
    logic [4:0]       w_clr_mask;

    // -------------------------------------------------------------------------
    // Prefix decoder: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_CODE;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_next;
            r_tmo   <= w_tmo_next;
        end
    end

    // -------------------------------------------------------------------------
    // Prefix decoder: next state and byte classification
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_tmo_next   = '0;
        w_make       = 1'b0;
        w_break      = 1'b0;

        if (scan_valid) begin
            case (r_state)
                WAIT_CODE: begin
                    if (scan_code == SC_EXT) begin
                        w_state_next = GOT_E0;
                    end else if (scan_code == SC_BREAK) begin
                        w_state_next = GOT_F0;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                GOT_E0: begin
                    // Extended makes are not game keys; only E0 F0 continues.
                    w_state_next = (scan_code == SC_BREAK) ? GOT_E0F0 : WAIT_CODE;
                end
                GOT_F0: begin
                    w_break      = 1'b1;
                    w_state_next = WAIT_CODE;
                end
                GOT_E0F0: begin
                    w_state_next = WAIT_CODE;
                end
                default: begin
                    w_state_next = WAIT_CODE;
                end
            endcase
        end else if (r_state != WAIT_CODE) begin
            // Idle cycle inside a prefix: count it, and give up on the
            // partial sequence once the limit is reached.
            if (r_tmo == TMO_LAST) begin
                w_state_next = WAIT_CODE;
            end else begin
                w_tmo_next = r_tmo + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Key tracking and emission decisions
    // -------------------------------------------------------------------------
    always_comb begin
        w_key_idx  = f_key_index(scan_code);
        w_key_mask = f_key_mask(w_key_idx);

        // A make for a key already down is a typematic repeat.
        w_fresh_key_make = w_make && (w_key_mask != 5'b00000)
                           && ((r_key_held & w_key_mask) == 5'b00000);
        w_emit_hit       = w_fresh_key_make && enable && (r_cooldown == '0);

        w_space_make  = w_make  && (scan_code == SC_SPACE) && !r_space_held;
        w_space_break = w_break && (scan_code == SC_SPACE);

        w_set_mask = w_fresh_key_make ? w_key_mask : 5'b00000;
        w_clr_mask = w_break          ? w_key_mask : 5'b00000;
    end

    // -------------------------------------------------------------------------
    // Registered outputs, held-key state and cooldown
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_key_held    <= 5'b00000;
            r_space_held  <= 1'b0;
            r_cooldown    <= '0;
            r_hit_code    <= 3'd0;
            r_start_pulse <= 1'b0;
        end else begin
            // A byte is either a make or a break, never both.
            r_key_held <= (r_key_held | w_set_mask) & ~w_clr_mask;

            if (w_space_make) begin
                r_space_held <= 1'b1;
            end else if (w_space_break) begin
                r_space_held <= 1'b0;
            end

            // Load wins over the decrement.
            if (w_emit_hit) begin
                r_cooldown <= CD_LOAD;
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - 1'b1;
            end

            // Outputs are rewritten every cycle, so each event is one cycle
            // wide even when two hits land on adjacent cycles.
            r_hit_code    <= w_emit_hit ? w_key_idx : 3'd0;
            r_start_pulse <= w_space_make;
        end
    end

    assign hit_code    = r_hit_code;
    assign start_pulse = r_start_pulse;
    assign key_held    = r_key_held;

endmodule

// File: tb/tb_hit_input_encoder.sv
// -----------------------------------------------------------------------------
// tb_hit_input_encoder
//
// Drives directed sequences followed by random PS/2 byte traffic into
// hit_input_encoder and compares every cycle's outputs with a behavioural
// model of the keyboard decoding rules.
// -----------------------------------------------------------------------------
module tb_hit_input_encoder;

    localparam int CD = 4;
    localparam int PT = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       enable;
    logic [2:0] hit_code;
    logic       start_pulse;
    logic [4:0] key_held;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    hit_input_encoder #(
        .COOLDOWN       (CD),
        .PREFIX_TIMEOUT (PT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .enable      (enable),
        .hit_code    (hit_code),
        .start_pulse (start_pulse),
        .key_held    (key_held)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_after_e0;    // an E0 prefix is pending
    bit       m_after_f0;    // an F0 prefix is pending
    int       m_idle;        // idle cycles spent with a prefix pending
    bit [5:1] m_down;        // mole keys currently down, indexed by hole
    bit       m_space;
    int       m_cool;
    int       e_hit;
    bit       e_start;

    function automatic int hole_of(input logic [7:0] b);
        case (b)
            8'h16: return 1;
            8'h1E: return 2;
            8'h26: return 3;
            8'h25: return 4;
            8'h2E: return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_after_e0 = 0; m_after_f0 = 0; m_idle = 0;
        m_down = '0; m_space = 0; m_cool = 0; e_hit = 0; e_start = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] b, input bit en);
        int  h;
        bit  fired;
        fired   = 0;
        e_hit   = 0;
        e_start = 0;
        if (!v) begin
            if (m_after_e0 || m_after_f0) begin
                m_idle++;
                if (m_idle >= PT) begin
                    m_after_e0 = 0; m_after_f0 = 0; m_idle = 0;
                end
            end
        end else begin
            m_idle = 0;
            h = hole_of(b);
            if (!m_after_e0 && !m_after_f0) begin
                if (b == 8'hE0)      m_after_e0 = 1;
                else if (b == 8'hF0) m_after_f0 = 1;
                else if (h != 0) begin
                    if (!m_down[h]) begin
                        m_down[h] = 1;
                        if (en && m_cool == 0) begin
                            e_hit = h;
                            fired = 1;
                        end
                    end
                end else if (b == 8'h29 && !m_space) begin
                    m_space = 1;
                    e_start = 1;
                end
            end else if (m_after_e0 && !m_after_f0) begin
                if (b == 8'hF0) m_after_f0 = 1;
                else            m_after_e0 = 0;
            end else if (m_after_f0 && !m_after_e0) begin
                if (h != 0)      m_down[h] = 0;
                if (b == 8'h29)  m_space = 0;
                m_after_f0 = 0;
            end else begin
                m_after_e0 = 0; m_after_f0 = 0;
            end
        end
        if (fired)           m_cool = CD;
        else if (m_cool > 0) m_cool--;
    endtask

    // Called at a falling edge: apply one cycle of input, check after the
    // rising edge, and return at the next falling edge.
    task automatic step(input bit v, input logic [7:0] b, input bit en);
        scan_valid = v;
        scan_code  = b;
        enable     = en;
        model_step(v, b, en);
        @(posedge clock);
        #1;
        check("hit_code", 32'(hit_code), 32'(e_hit));
        check("start_pulse", 32'(start_pulse), 32'(e_start));
        check("key_held", 32'(key_held), 32'(m_down));
        @(negedge clock);
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(0, 8'h00, en);
    endtask

    int pulses;

    initial begin
        logic [7:0] pick [9];
        pick[0] = 8'h16; pick[1] = 8'h1E; pick[2] = 8'h26; pick[3] = 8'h25;
        pick[4] = 8'h2E; pick[5] = 8'h29; pick[6] = 8'hE0; pick[7] = 8'hF0;
        pick[8] = 8'h00;

        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        enable     = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_hit", 32'(hit_code), 0);
        check("rst_start", 32'(start_pulse), 0);
        check("rst_held", 32'(key_held), 0);
        reset = 1'b0;

        // Single hit on key 2.
        step(1, 8'h1E, 1);
        check("tp1_hit", 32'(hit_code), 2);
        check("tp1_held", 32'(key_held), 32'h02);
        idle(1, 1);
        check("tp1_hit_gone", 32'(hit_code), 0);
        step(1, 8'hF0, 1); step(1, 8'h1E, 1);
        idle(5, 1);

        // Typematic repeats, release, press again: two pulses.
        pulses = 0;
        step(1, 8'h16, 1); if (hit_code == 3'd1) pulses++;
        step(1, 8'h16, 1); if (hit_code == 3'd1) pulses++;
        step(1, 8'h16, 1); if (hit_code == 3'd1) pulses++;
        step(1, 8'hF0, 1); if (hit_code == 3'd1) pulses++;
        step(1, 8'h16, 1); if (hit_code == 3'd1) pulses++;
        check("tp2_released", 32'(key_held[0]), 0);
        step(1, 8'h16, 1); if (hit_code == 3'd1) pulses++;
        idle(2, 1);        if (hit_code == 3'd1) pulses++;
        check("tp2_pulses", 32'(pulses), 2);
        step(1, 8'hF0, 1); step(1, 8'h16, 1);
        idle(5, 1);

        // Cooldown drops the second key.
        step(1, 8'h16, 1);
        idle(1, 1);
        step(1, 8'h26, 1);
        check("tp3_dropped", 32'(hit_code), 0);
        check("tp3_held", 32'(key_held), 32'h05);
        step(1, 8'hF0, 1); step(1, 8'h26, 1);
        idle(5, 1);
        step(1, 8'h26, 1);
        check("tp3_hit3", 32'(hit_code), 3);
        step(1, 8'hF0, 1); step(1, 8'h16, 1);
        step(1, 8'hF0, 1); step(1, 8'h26, 1);
        idle(5, 1);

        // Disabled game: no hit, but start still works.
        step(1, 8'h2E, 0);
        check("tp4_nohit", 32'(hit_code), 0);
        check("tp4_held4", 32'(key_held[4]), 1);
        step(1, 8'h29, 0);
        check("tp4_start", 32'(start_pulse), 1);
        idle(1, 0);
        step(1, 8'h29, 0);
        check("tp4_no_restart", 32'(start_pulse), 0);
        step(1, 8'hF0, 0); step(1, 8'h29, 0);
        step(1, 8'hF0, 0); step(1, 8'h2E, 0);
        idle(2, 1);

        // Extended sequences and prefix timeout.
        step(1, 8'hE0, 1); step(1, 8'h16, 1);
        step(1, 8'hE0, 1); step(1, 8'hF0, 1); step(1, 8'h16, 1);
        check("tp5_ext_held", 32'(key_held), 0);
        step(1, 8'hF0, 1);
        idle(PT, 1);
        step(1, 8'h25, 1);
        check("tp5_timeout_hit", 32'(hit_code), 4);
        step(1, 8'hF0, 1); step(1, 8'h25, 1);
        idle(5, 1);

        // Asynchronous reset after an F0 prefix.
        step(1, 8'h16, 1);
        step(1, 8'hF0, 1);
        #2 reset = 1'b1;
        #1;
        check("tp6_async_held", 32'(key_held), 0);
        check("tp6_async_hit", 32'(hit_code), 0);
        check("tp6_async_start", 32'(start_pulse), 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        step(1, 8'h16, 1);
        check("tp6_make_after_reset", 32'(hit_code), 1);
        idle(5, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit         v;
            bit         en;
            logic [7:0] b;
            v  = ($urandom_range(0, 2) != 0);
            en = ($urandom_range(0, 7) != 0);
            b  = pick[$urandom_range(0, 8)];
            if (b == 8'h00) b = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                for (int j = 0; j < PT + 2; j++) step(0, 8'h00, en);
            end
            step(v, b, en);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
